// File: rtl/planet_emp_game_ctl.sv
// Planet Empire game sequencer: owns idle/play/win/over, scores missile hits,
// enforces the game time limit and long-push abort, and drives the single sound output.
module planet_emp_game_ctl #(
  parameter int C_GAME_TICKS  = 36_600_000,
  parameter int C_LPUSH_TICKS = 1_000_000,
  parameter int C_WIN_SCORE   = 8,
  parameter int C_TONE_HALF   = 150,
  parameter int C_FIRE_LEN    = 50_000,
  parameter int C_HIT_LEN     = 200_000
) (
  input  logic       CK_i,
  input  logic       ARST_i,
  input  logic       EE_i,
  input  logic       PSW_i,
  input  logic       MSL_END_i,
  input  logic [7:0] EMP_ALIVE_i,
  output logic       RUN_o,
  output logic       GAME_RST_o,
  output logic       FIRE_o,
  output logic       HIT_o,
  output logic [3:0] SCORE_o,
  output logic [1:0] STATE_o,
  output logic       SND_o
);

  function automatic int cntWidth(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  localparam int TMR_W  = cntWidth(C_GAME_TICKS);
  localparam int HOLD_W = cntWidth(C_LPUSH_TICKS + 1);
  localparam int FLEN_W = cntWidth(C_FIRE_LEN + 1);
  localparam int HLEN_W = cntWidth(C_HIT_LEN + 1);
  localparam int TONE_W = cntWidth(2 * C_TONE_HALF);

  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(C_GAME_TICKS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(C_LPUSH_TICKS - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(C_LPUSH_TICKS);
  localparam logic [FLEN_W-1:0] FIRE_LEN  = FLEN_W'(C_FIRE_LEN);
  localparam logic [HLEN_W-1:0] HIT_LEN   = HLEN_W'(C_HIT_LEN);
  localparam logic [TONE_W-1:0] HALF_LAST = TONE_W'(C_TONE_HALF - 1);
  localparam logic [TONE_W-1:0] HIT_HALF_LAST = TONE_W'(2 * C_TONE_HALF - 1);
  localparam logic [3:0]        WIN_SCORE = 4'(C_WIN_SCORE);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_WIN  = 2'd2,
    ST_OVER = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_FIRE = 2'd1,
    SRC_HIT  = 2'd2,
    SRC_WIN  = 2'd3
  } src_e;

  state_e              state_q, state_d;
  src_e                src_q, src_d;
  logic                psw_q, end_q;
  logic                run_q, run_d;
  logic                grst_q, grst_d;
  logic                fire_q, fire_d;
  logic                hit_q, hit_d;
  logic                inflight_q, inflight_d;
  logic                snd_q, snd_d;
  logic [3:0]          score_q, score_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [FLEN_W-1:0]   fcnt_q, fcnt_d;
  logic [HLEN_W-1:0]   hcnt_q, hcnt_d;
  logic [TONE_W-1:0]   tcnt_q, tcnt_d;
  logic [TONE_W-1:0]   half_last;
  logic                psw_re, end_re, lpush;

  // Only the target stage matters for scoring.
  logic emp_unused;
  assign emp_unused = ^EMP_ALIVE_i[6:0];

  assign psw_re = PSW_i & ~psw_q;
  assign end_re = MSL_END_i & ~end_q;
  assign lpush  = PSW_i & EE_i & (hold_q == HOLD_LAST);

  always_comb begin
    state_d    = state_q;
    grst_d     = 1'b0;
    fire_d     = 1'b0;
    hit_d      = 1'b0;
    score_d    = score_q;
    inflight_d = inflight_q;
    timer_d    = timer_q;
    fcnt_d     = (EE_i && fcnt_q != '0) ? fcnt_q - 1'b1 : fcnt_q;
    hcnt_d     = (EE_i && hcnt_q != '0) ? hcnt_q - 1'b1 : hcnt_q;

    if (!PSW_i) begin
      hold_d = '0;
    end else if (EE_i && hold_q != HOLD_MAX) begin
      hold_d = hold_q + 1'b1;
    end else begin
      hold_d = hold_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (psw_re) begin
          grst_d     = 1'b1;
          score_d    = '0;
          timer_d    = '0;
          inflight_d = 1'b0;
          fcnt_d     = '0;
          hcnt_d     = '0;
          state_d    = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (EE_i && timer_q != TMR_LAST) begin
          timer_d = timer_q + 1'b1;
        end
        if (end_re) begin
          inflight_d = 1'b0;
          if (EMP_ALIVE_i[7]) begin
            hit_d   = 1'b1;
            score_d = (score_q == 4'd15) ? 4'd15 : score_q + 4'd1;
            hcnt_d  = HIT_LEN;
          end
        end
        // A missile landing in this same cycle frees the launcher for the new press.
        if (psw_re && (!inflight_q || end_re)) begin
          fire_d     = 1'b1;
          inflight_d = 1'b1;
          fcnt_d     = FIRE_LEN;
        end
        if (score_d >= WIN_SCORE) begin
          state_d = ST_WIN;
        end else if (EE_i && timer_q == TMR_LAST) begin
          state_d = ST_OVER;
        end
      end
      default: begin
        if (psw_re) begin
          state_d = ST_IDLE;
        end
      end
    endcase

    if (lpush) begin
      grst_d     = 1'b1;
      fire_d     = 1'b0;
      hit_d      = 1'b0;
      score_d    = '0;
      timer_d    = '0;
      inflight_d = 1'b0;
      fcnt_d     = '0;
      hcnt_d     = '0;
      state_d    = ST_IDLE;
    end

    run_d = (state_d == ST_PLAY);
  end

  // Sound source is chosen from registered state; hit outranks fire, win is continuous.
  always_comb begin
    src_d = SRC_NONE;
    case (state_q)
      ST_WIN:  src_d = SRC_WIN;
      ST_PLAY: begin
        if (hcnt_q != '0) begin
          src_d = SRC_HIT;
        end else if (fcnt_q != '0) begin
          src_d = SRC_FIRE;
        end
      end
      default: src_d = SRC_NONE;
    endcase

    half_last = (src_d == SRC_HIT) ? HIT_HALF_LAST : HALF_LAST;

    tcnt_d = tcnt_q;
    snd_d  = snd_q;
    if (src_d == SRC_NONE || src_d != src_q) begin
      tcnt_d = '0;
      snd_d  = 1'b0;
    end else if (EE_i) begin
      if (tcnt_q == half_last) begin
        tcnt_d = '0;
        snd_d  = ~snd_q;
      end else begin
        tcnt_d = tcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CK_i or posedge ARST_i) begin
    if (ARST_i) begin
      state_q    <= ST_IDLE;
      src_q      <= SRC_NONE;
      psw_q      <= 1'b0;
      end_q      <= 1'b0;
      run_q      <= 1'b0;
      grst_q     <= 1'b0;
      fire_q     <= 1'b0;
      hit_q      <= 1'b0;
      inflight_q <= 1'b0;
      snd_q      <= 1'b0;
      score_q    <= '0;
      timer_q    <= '0;
      hold_q     <= '0;
      fcnt_q     <= '0;
      hcnt_q     <= '0;
      tcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      psw_q      <= PSW_i;
      end_q      <= MSL_END_i;
      run_q      <= run_d;
      grst_q     <= grst_d;
      fire_q     <= fire_d;
      hit_q      <= hit_d;
      inflight_q <= inflight_d;
      snd_q      <= snd_d;
      score_q    <= score_d;
      timer_q    <= timer_d;
      hold_q     <= hold_d;
      fcnt_q     <= fcnt_d;
      hcnt_q     <= hcnt_d;
      tcnt_q     <= tcnt_d;
    end
  end

  assign RUN_o      = run_q;
  assign GAME_RST_o = grst_q;
  assign FIRE_o     = fire_q;
  assign HIT_o      = hit_q;
  assign SCORE_o    = score_q;
  assign STATE_o    = state_q;
  assign SND_o      = snd_q;

endmodule

// File: tb/tb_planet_emp_game_ctl.sv
// Directed bench for planet_emp_game_ctl with shortened timing parameters
// (game 100 ticks, long push 20 ticks, tone half 4, fire 30, hit 50).
module tb_planet_emp_game_ctl;

  logic       CK = 1'b0;
  logic       ARST, EE, PSW, MSL;
  logic [7:0] EMP;
  logic       RUN, GRST, FIRE, HIT, SND;
  logic [3:0] SCORE;
  logic [1:0] STATE;

  int nCompared   = 0;
  int nMismatched = 0;
  int grstCount;

  planet_emp_game_ctl #(
    .C_GAME_TICKS (100),
    .C_LPUSH_TICKS(20),
    .C_WIN_SCORE  (8),
    .C_TONE_HALF  (4),
    .C_FIRE_LEN   (30),
    .C_HIT_LEN    (50)
  ) dut (
    .CK_i       (CK),
    .ARST_i     (ARST),
    .EE_i       (EE),
    .PSW_i      (PSW),
    .MSL_END_i  (MSL),
    .EMP_ALIVE_i(EMP),
    .RUN_o      (RUN),
    .GAME_RST_o (GRST),
    .FIRE_o     (FIRE),
    .HIT_o      (HIT),
    .SCORE_o    (SCORE),
    .STATE_o    (STATE),
    .SND_o      (SND)
  );

  always #5 CK = ~CK;

  task automatic checkOutput(input string tag, input int act, input int exp);
    nCompared++;
    if (act != exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic stepCycles(input int n);
    repeat (n) begin
      @(posedge CK);
      #1;
    end
  endtask

  // Inputs are set just after an edge and take effect at the next one.
  task automatic applyStimulus(input logic psw, input logic msl, input logic ee);
    PSW = psw;
    MSL = msl;
    EE  = ee;
    stepCycles(1);
  endtask

  initial begin
    ARST = 1'b1;
    PSW  = 1'b0;
    MSL  = 1'b0;
    EE   = 1'b0;
    EMP  = 8'h80;
    stepCycles(2);
    checkOutput("rst_state", STATE, 0);
    checkOutput("rst_run", RUN, 0);
    checkOutput("rst_grst", GRST, 0);
    checkOutput("rst_fire", FIRE, 0);
    checkOutput("rst_hit", HIT, 0);
    checkOutput("rst_score", SCORE, 0);
    checkOutput("rst_snd", SND, 0);
    ARST = 1'b0;
    stepCycles(2);
    checkOutput("deassert_grst", GRST, 0);
    checkOutput("deassert_state", STATE, 0);

    // Start game 1
    applyStimulus(1, 0, 0);
    checkOutput("start_grst", GRST, 1);
    checkOutput("start_state", STATE, 1);
    checkOutput("start_run", RUN, 1);
    checkOutput("start_score", SCORE, 0);
    applyStimulus(0, 0, 0);
    checkOutput("start_grst_once", GRST, 0);

    // Fire, then a second press while in flight is ignored
    applyStimulus(1, 0, 0);
    checkOutput("fire_pulse", FIRE, 1);
    applyStimulus(0, 0, 0);
    checkOutput("fire_once", FIRE, 0);
    applyStimulus(1, 0, 0);
    checkOutput("fire_ignored", FIRE, 0);
    applyStimulus(0, 0, 0);

    // Hit, then hit tone toggles every 8 ticks
    applyStimulus(0, 1, 0);
    checkOutput("hit_pulse", HIT, 1);
    checkOutput("hit_score1", SCORE, 1);
    applyStimulus(0, 0, 0);
    checkOutput("hit_once", HIT, 0);
    checkOutput("hit_snd_start", SND, 0);
    repeat (7) applyStimulus(0, 0, 1);
    checkOutput("hit_snd_7", SND, 0);
    applyStimulus(0, 0, 1);
    checkOutput("hit_snd_8", SND, 1);
    repeat (8) applyStimulus(0, 0, 1);
    checkOutput("hit_snd_16", SND, 0);

    // Miss with target stage empty, then launcher is free again
    applyStimulus(1, 0, 0);
    checkOutput("fire2_pulse", FIRE, 1);
    applyStimulus(0, 0, 0);
    EMP = 8'h7F;
    applyStimulus(0, 1, 0);
    checkOutput("miss_hit", HIT, 0);
    checkOutput("miss_score", SCORE, 1);
    applyStimulus(0, 0, 0);
    EMP = 8'h80;
    applyStimulus(1, 0, 0);
    checkOutput("refire_pulse", FIRE, 1);
    applyStimulus(0, 0, 0);

    // Landing and new press in the same cycle: both pulses
    for (int k = 2; k <= 7; k++) begin
      applyStimulus(1, 1, 0);
      checkOutput("sim_fire", FIRE, 1);
      checkOutput("sim_hit", HIT, 1);
      checkOutput("sim_score", SCORE, k);
      applyStimulus(0, 0, 0);
    end

    // Timer sits at 16; bring it to 99, then score the 8th hit on the final tick
    repeat (83) applyStimulus(0, 0, 1);
    checkOutput("pre_final_state", STATE, 1);
    applyStimulus(0, 1, 1);
    checkOutput("final_tick_state", STATE, 2);
    checkOutput("final_tick_run", RUN, 0);
    checkOutput("final_tick_score", SCORE, 8);
    checkOutput("final_tick_hit", HIT, 1);

    // WIN tone toggles every 4 ticks
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("win_snd_start", SND, 0);
    repeat (3) applyStimulus(0, 0, 1);
    checkOutput("win_snd_3", SND, 0);
    applyStimulus(0, 0, 1);
    checkOutput("win_snd_4", SND, 1);
    repeat (4) applyStimulus(0, 0, 1);
    checkOutput("win_snd_8", SND, 0);
    checkOutput("win_score_held", SCORE, 8);

    // Press leaves WIN without a datapath clear
    applyStimulus(1, 0, 0);
    checkOutput("win_exit_state", STATE, 0);
    checkOutput("win_exit_grst", GRST, 0);
    applyStimulus(0, 0, 0);
    checkOutput("idle_snd", SND, 0);

    // Game 2: time out with no hits at exactly the 100th tick
    applyStimulus(1, 0, 0);
    checkOutput("g2_grst", GRST, 1);
    checkOutput("g2_score_clr", SCORE, 0);
    applyStimulus(0, 0, 0);
    repeat (99) applyStimulus(0, 0, 1);
    checkOutput("g2_tick99_state", STATE, 1);
    applyStimulus(0, 0, 1);
    checkOutput("g2_over_state", STATE, 3);
    checkOutput("g2_over_run", RUN, 0);
    applyStimulus(0, 0, 0);
    checkOutput("g2_over_snd", SND, 0);

    // Game 3: score once, then long push
    applyStimulus(1, 0, 0);
    checkOutput("over_exit_state", STATE, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 0);
    checkOutput("g3_state", STATE, 1);
    applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 1, 0);
    checkOutput("g3_score", SCORE, 1);
    applyStimulus(0, 0, 0);

    applyStimulus(1, 0, 1);
    checkOutput("lp_fire", FIRE, 1);
    repeat (18) applyStimulus(1, 0, 1);
    checkOutput("lp_19_grst", GRST, 0);
    checkOutput("lp_19_state", STATE, 1);
    applyStimulus(1, 0, 1);
    checkOutput("lp_20_grst", GRST, 1);
    checkOutput("lp_20_state", STATE, 0);
    checkOutput("lp_20_score", SCORE, 0);
    checkOutput("lp_20_run", RUN, 0);
    grstCount = 0;
    repeat (30) begin
      applyStimulus(1, 0, 1);
      if (GRST) grstCount++;
    end
    checkOutput("lp_hold_pulses", grstCount, 0);
    applyStimulus(0, 0, 0);
    checkOutput("lp_idle_state", STATE, 0);
    checkOutput("lp_idle_snd", SND, 0);

    // Game 4: async reset in the middle of a fire tone
    applyStimulus(1, 0, 0);
    checkOutput("g4_state", STATE, 1);
    applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 1);
    checkOutput("g4_fire", FIRE, 1);
    repeat (5) applyStimulus(0, 0, 1);
    checkOutput("g4_fire_snd", SND, 1);
    ARST = 1'b1;
    #1;
    checkOutput("arst_state", STATE, 0);
    checkOutput("arst_run", RUN, 0);
    checkOutput("arst_grst", GRST, 0);
    checkOutput("arst_fire", FIRE, 0);
    checkOutput("arst_hit", HIT, 0);
    checkOutput("arst_score", SCORE, 0);
    checkOutput("arst_snd", SND, 0);
    stepCycles(2);
    ARST = 1'b0;
    stepCycles(2);
    checkOutput("post_arst_state", STATE, 0);
    checkOutput("post_arst_snd", SND, 0);
    checkOutput("post_arst_grst", GRST, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/planet_emp_game_ctl.md
# planet_emp_game_ctl

Game sequencer for the Planet Empire core. It owns the game state (idle, play, win, over) and gates the missile and empire shift datapath through `RUN_o`, `GAME_RST_o` and `FIRE_o`. It scores hits when the missile reaches its last stage while the empire occupies the target stage, and enforces the game time limit and the long-push abort. It also arbitrates fire and hit sound requests onto the single `SND_o` output.

## Interface
- `C_GAME_TICKS`, 36_600_000, game length in `EE_i` ticks.
- `C_LPUSH_TICKS`, 1_000_000, hold time in ticks for long-push abort.
- `C_WIN_SCORE`, 8, hits needed to win; legal range 1..15.
- `C_TONE_HALF`, 150, fire/win tone half period in ticks; the hit tone uses 2× this.
- `C_FIRE_LEN`, 50_000, fire tone duration in ticks.
- `C_HIT_LEN`, 200_000, hit tone duration in ticks.
- `CK_i`  in  1  single clock; all logic on its rising edge.
- `ARST_i`  in  1  asynchronous reset, active-high.
- `EE_i`  in  1  one-cycle tick enable (1 µs prescaler carry).
- `PSW_i`  in  1  push switch, 1 = pressed; already synchronized and debounced.
- `MSL_END_i`  in  1  level, missile in final stage.
- `EMP_ALIVE_i`  in  8  empire stage occupancy; bit 7 is the target stage.
- `RUN_o`  out  1  enables the missile/empire counters.
- `GAME_RST_o`  out  1  one-cycle clear of the datapath.
- `FIRE_o`  out  1  one-cycle missile launch request.
- `HIT_o`  out  1  one-cycle hit strobe.
- `SCORE_o`  out  4  hit count.
- `STATE_o`  out  2  0 IDLE, 1 PLAY, 2 WIN, 3 OVER.
- `SND_o`  out  1  square-wave sound.

## Operation
- **Edge detection:** registered copies of `PSW_i` and `MSL_END_i` give rising-edge pulses `psw_re` and `end_re`, evaluated every clock and not gated by `EE_i`.
- **IDLE:** `RUN_o`=0.
  - On `psw_re`: pulse `GAME_RST_o`, clear score, timer, in-flight flag and tones, then go to PLAY.
- **PLAY:** `RUN_o`=1. The timer increments on each `EE_i`.
  - `psw_re` with in-flight=0: pulse `FIRE_o` and set in-flight.
  - `psw_re` with in-flight=1: ignored.
  - `end_re`: clear in-flight. If `EMP_ALIVE_i[7]`=1, pulse `HIT_o`, increment the score and start the hit tone. Otherwise it is a miss and nothing else happens.
  - Score reaches `C_WIN_SCORE`: go to WIN.
  - `EE_i` while the timer = `C_GAME_TICKS`-1: go to OVER.
- **WIN / OVER:** `RUN_o`=0 and the score is held.
  - On `psw_re`: go to IDLE. This does not pulse `GAME_RST_o`.
- **Long push:** the hold counter clears while `PSW_i`=0 and counts `EE_i` ticks while `PSW_i`=1.
  - When it reaches `C_LPUSH_TICKS`, from any state: pulse `GAME_RST_o`, clear the score, go to IDLE, and saturate the counter so it fires only once per hold.
  - The `psw_re` that began the hold has already been acted on.
- **Sound:**
  - Fire tone starts on `FIRE_o` and lasts `C_FIRE_LEN` ticks.
  - Hit tone lasts `C_HIT_LEN` ticks.
  - Priority: hit > fire. A new hit restarts the hit tone. A fire during a hit tone is not heard.
  - WIN plays a continuous tone at `C_TONE_HALF`. IDLE and OVER are silent.
  - The `SND_o` toggle counter restarts when the selected source changes, and `SND_o` is forced to 0 when no source is active.
- **Arithmetic:** the score saturates at 15. The tick counters are sized with the log2 constant function from their parameters and never wrap.

## Timing
- **Reset values:** `STATE_o`=IDLE, `RUN_o`=0, `GAME_RST_o`=`FIRE_o`=`HIT_o`=0, `SCORE_o`=0, `SND_o`=0, all counters and flags 0.
- All outputs are registered.
- **Edge latency:** if `PSW_i` or `MSL_END_i` is first 1 in cycle n, the resulting pulse (`FIRE_o`, `GAME_RST_o` or `HIT_o`) is high only in cycle n+1, and the state change is visible in n+1.
- **`RUN_o`** follows `STATE_o` in the same cycle.
- **Simultaneous events in one cycle, in priority order:**
  1. Long push wins over everything.
  2. A hit counted on the final tick is scored first; if it reaches `C_WIN_SCORE`, the result is WIN, not OVER.
  3. `end_re` and `psw_re` together: the in-flight flag clears and the launch is accepted in the same cycle, so `FIRE_o` and `HIT_o` may both pulse.
- **Reset mid-game:** `ARST_i` returns every output to its reset value immediately. No pulse is emitted on deassert.

## Test plan
- Reset, then `PSW_i` 0→1 → `GAME_RST_o` one cycle, `STATE_o`=1, `RUN_o`=1, `SCORE_o`=0.
- In PLAY, press → `FIRE_o` one cycle. Second press before `MSL_END_i` → no `FIRE_o`. `MSL_END_i` rise with `EMP_ALIVE_i`=8'h80 → `HIT_o` one cycle, `SCORE_o`=1, `SND_o` toggles every 300 ticks.
- `MSL_END_i` rise with `EMP_ALIVE_i`=8'h7F → no `HIT_o`, score unchanged. 8 hits with `C_WIN_SCORE`=8 → `STATE_o`=2, `RUN_o`=0, `SND_o` toggling every 150 ticks. Press → `STATE_o`=0.
- `C_GAME_TICKS`=100 with no hits → OVER exactly at the 100th `EE_i`, `SND_o`=0. 8th hit on the 100th tick → `STATE_o`=2.
- Hold `PSW_i` for `C_LPUSH_TICKS` ticks during PLAY → a single `GAME_RST_o`, `STATE_o`=0, `SCORE_o`=0. Continued hold → no further pulses.
- Assert `ARST_i` mid-tone in PLAY → all outputs at reset values in the same cycle. Deassert → IDLE, silent.
